// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches one instruction word, drives an external ALU and
// writes the result back into a small register file, signalling completion with done.
module control_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [31:0]               instrIn,
  input  logic                      instrValid,
  output logic                      instrReady,
  output logic [6:0]                controlUnitOut,
  output logic [DATA_WIDTH-1:0]     aluA,
  output logic [DATA_WIDTH-1:0]     aluB,
  input  logic [DATA_WIDTH-1:0]     aluOut,
  input  logic                      cOut,
  input  logic                      negative,
  input  logic                      zero,
  input  logic                      parity,
  input  logic                      overflow,
  output logic                      done,
  output logic [5:0]                status,
  input  logic [REG_ADDR_WIDTH-1:0] readAddr,
  output logic [DATA_WIDTH-1:0]     readData
);

  localparam int unsigned NumRegs   = 1 << REG_ADDR_WIDTH;
  localparam logic [5:0]  MaxOpcode = 6'd5;

  typedef enum logic [1:0] {StIdle, StDecode, StExecute, StWriteback} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               instr_q;
  logic [DATA_WIDTH-1:0]     regs_q [NumRegs];
  logic [6:0]                ctrl_q;
  logic [DATA_WIDTH-1:0]     alu_a_q, alu_b_q, result_q;
  logic [4:0]                flags_q;
  logic                      illegal_q;
  logic                      done_q;
  logic [5:0]                status_q;

  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
  logic [DATA_WIDTH-1:0]     imm_sext;
  logic                      legal;

  assign opcode   = instr_q[31:25];
  assign rd       = instr_q[24 -: REG_ADDR_WIDTH];
  assign rs1      = instr_q[21 -: REG_ADDR_WIDTH];
  assign rs2      = instr_q[18 -: REG_ADDR_WIDTH];
  assign imm_sext = {{(DATA_WIDTH-16){instr_q[15]}}, instr_q[15:0]};
  assign legal    = (opcode[5:0] <= MaxOpcode);

  assign instrReady     = (state_q == StIdle);
  assign controlUnitOut = ctrl_q;
  assign aluA           = alu_a_q;
  assign aluB           = alu_b_q;
  assign done           = done_q;
  assign status         = status_q;
  // r0 is never written, but the read port masks it anyway so it is hard-wired zero.
  assign readData       = (readAddr == '0) ? '0 : regs_q[readAddr];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (instrValid) state_d = StDecode;
      StDecode:    state_d = legal ? StExecute : StWriteback;
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      instr_q   <= '0;
      ctrl_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (instrValid) instr_q <= instrIn;
        end
        StDecode: begin
          illegal_q <= !legal;
          if (legal) begin
            ctrl_q  <= {1'b0, opcode[5:0]};
            alu_a_q <= regs_q[rs1];
            alu_b_q <= opcode[6] ? imm_sext : regs_q[rs2];
          end
        end
        StExecute: begin
          result_q <= aluOut;
          flags_q  <= {overflow, parity, zero, negative, cOut};
        end
        StWriteback: begin
          if (!illegal_q && (rd != '0)) regs_q[rd] <= result_q;
          status_q <= illegal_q ? 6'b100000 : {1'b0, flags_q};
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a behavioural ALU, a table of instructions with hand-derived
// results checked through a scoreboard queue, plus reset-abort and back-to-back sequences.
module tb_control_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetN;
  logic [31:0]   instrIn;
  logic          instrValid;
  logic          instrReady;
  logic [6:0]    controlUnitOut;
  logic [DW-1:0] aluA, aluB, aluOut;
  logic          cOut, negative, zero, parity, overflow;
  logic          done;
  logic [5:0]    status;
  logic [2:0]    readAddr;
  logic [DW-1:0] readData;

  control_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(3)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .instrIn        (instrIn),
    .instrValid     (instrValid),
    .instrReady     (instrReady),
    .controlUnitOut (controlUnitOut),
    .aluA           (aluA),
    .aluB           (aluB),
    .aluOut         (aluOut),
    .cOut           (cOut),
    .negative       (negative),
    .zero           (zero),
    .parity         (parity),
    .overflow       (overflow),
    .done           (done),
    .status         (status),
    .readAddr       (readAddr),
    .readData       (readData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; cOut on SUB is the carry of a + ~b + 1 (1 = no borrow).
  logic [32:0] sum;
  always_comb begin
    sum      = '0;
    aluOut   = '0;
    cOut     = 1'b0;
    overflow = 1'b0;
    case (controlUnitOut)
      7'd0: aluOut = aluA | aluB;
      7'd1: aluOut = aluA & aluB;
      7'd2: aluOut = aluA ^ aluB;
      7'd3: begin
        sum      = {1'b0, aluA} + {1'b0, aluB};
        aluOut   = sum[31:0];
        cOut     = sum[32];
        overflow = (aluA[31] == aluB[31]) && (aluOut[31] != aluA[31]);
      end
      7'd4: begin
        sum      = {1'b0, aluA} + {1'b0, ~aluB} + 33'd1;
        aluOut   = sum[31:0];
        cOut     = sum[32];
        overflow = (aluA[31] != aluB[31]) && (aluOut[31] != aluA[31]);
      end
      7'd5: aluOut = aluA << aluB[4:0];
      default: aluOut = '0;
    endcase
    negative = aluOut[31];
    zero     = (aluOut == '0);
    parity   = ^aluOut;
  end

  typedef struct {
    logic [31:0] instr;
    logic        legal;
    logic [6:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rd;
    logic [31:0] wval;
    logic [5:0]  stat;
    int          lat;
  } vec_t;

  vec_t        vecs[11];
  vec_t        sb[$];
  logic [31:0] exp_regs[8];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic vec_t mv(input logic [31:0] instr, input logic legal, input logic [6:0] ctrl,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] wval,
                              input logic [5:0] stat);
    vec_t v;
    v.instr = instr;
    v.legal = legal;
    v.ctrl  = ctrl;
    v.a     = a;
    v.b     = b;
    v.rd    = instr[24:22];
    v.wval  = wval;
    v.stat  = stat;
    v.lat   = legal ? 3 : 2;
    return v;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      readAddr = 3'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), readData, exp_regs[i]);
    end
    @(negedge clk);
  endtask

  // Waits for done at negedges; returns the latency seen relative to the accept edge.
  task automatic wait_done(input int acc, output int lat);
    int n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done timeout: got no done expected done within 10 cycles");
      lat = -1;
    end else begin
      lat = cyc - acc;
    end
  endtask

  task automatic finish_instr(input int acc, input string tag);
    vec_t e;
    int   lat;
    wait_done(acc, lat);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
      return;
    end
    e = sb.pop_front();
    if (lat >= 0) begin
      checks++;
      chk($sformatf("%s latency", tag), 32'(lat), 32'(e.lat));
      checks--;
      chk($sformatf("%s status", tag), 32'(status), 32'(e.stat));
      if (e.legal && e.rd != 3'd0) exp_regs[e.rd] = e.wval;
    end
    @(negedge clk);
    chk($sformatf("%s done width", tag), 32'(done), 32'd0);
    chk($sformatf("%s status hold", tag), 32'(status), 32'(e.stat));
  endtask

  task automatic issue(input vec_t v, input string tag);
    int n = 0;
    int acc;
    while (!instrReady && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s ready", tag), 32'(instrReady), 32'd1);
    instrIn    = v.instr;
    instrValid = 1'b1;
    acc        = cyc + 1;
    sb.push_back(v);
    @(negedge clk);
    instrValid = 1'b0;
    instrIn    = $urandom;
    chk($sformatf("%s busy", tag), 32'(instrReady), 32'd0);
    @(negedge clk);
    if (v.legal) begin
      chk($sformatf("%s ctrl", tag), 32'(controlUnitOut), 32'(v.ctrl));
      chk($sformatf("%s aluA", tag), aluA, v.a);
      chk($sformatf("%s aluB", tag), aluB, v.b);
    end
    finish_instr(acc, tag);
    check_regs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, lat, seen;
    vec_t b1, b2;

    vecs[0]  = mv(mk(7'h40, 3'd1, 3'd0, 3'd0, 16'h0005), 1'b1, 7'd0, 32'h0, 32'h5,
                  32'h5, 6'b000000);
    vecs[1]  = mv(mk(7'h03, 3'd2, 3'd1, 3'd1, 16'h0000), 1'b1, 7'd3, 32'h5, 32'h5,
                  32'hA, 6'b000000);
    vecs[2]  = mv(mk(7'h04, 3'd3, 3'd0, 3'd1, 16'h0000), 1'b1, 7'd4, 32'h0, 32'h5,
                  32'hFFFFFFFB, 6'b001010);
    vecs[3]  = mv(mk(7'h40, 3'd4, 3'd0, 3'd0, 16'h8000), 1'b1, 7'd0, 32'h0, 32'hFFFF8000,
                  32'hFFFF8000, 6'b001010);
    vecs[4]  = mv(mk(7'h40, 3'd0, 3'd0, 3'd0, 16'h8000), 1'b1, 7'd0, 32'h0, 32'hFFFF8000,
                  32'hFFFF8000, 6'b001010);
    vecs[5]  = mv(mk(7'h07, 3'd5, 3'd1, 3'd2, 16'h1234), 1'b0, 7'd0, 32'h0, 32'h0,
                  32'h0, 6'b100000);
    vecs[6]  = mv(mk(7'h01, 3'd5, 3'd3, 3'd4, 16'h0000), 1'b1, 7'd1, 32'hFFFFFFFB,
                  32'hFFFF8000, 32'hFFFF8000, 6'b001010);
    vecs[7]  = mv(mk(7'h02, 3'd6, 3'd3, 3'd3, 16'h0000), 1'b1, 7'd2, 32'hFFFFFFFB,
                  32'hFFFFFFFB, 32'h0, 6'b000100);
    vecs[8]  = mv(mk(7'h45, 3'd7, 3'd1, 3'd0, 16'h0004), 1'b1, 7'd5, 32'h5, 32'h4,
                  32'h50, 6'b000000);
    vecs[9]  = mv(mk(7'h43, 3'd1, 3'd4, 3'd0, 16'h8000), 1'b1, 7'd3, 32'hFFFF8000,
                  32'hFFFF8000, 32'hFFFF0000, 6'b000011);
    vecs[10] = mv(mk(7'h46, 3'd2, 3'd0, 3'd0, 16'h0000), 1'b0, 7'd0, 32'h0, 32'h0,
                  32'h0, 6'b100000);
    foreach (exp_regs[i]) exp_regs[i] = '0;

    resetN     = 1'b0;
    instrValid = 1'b0;
    instrIn    = '0;
    readAddr   = '0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    #1;
    chk("reset ready", 32'(instrReady), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset status", 32'(status), 32'd0);
    chk("reset ctrl", 32'(controlUnitOut), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset pulse while an instruction sits in EXECUTE.
    instrIn    = mk(7'h03, 3'd6, 3'd1, 3'd1, 16'h0000);
    instrValid = 1'b1;
    @(negedge clk);
    instrValid = 1'b0;
    @(negedge clk);
    #1;
    resetN = 1'b0;
    #1;
    chk("abort done", 32'(done), 32'd0);
    chk("abort ready", 32'(instrReady), 32'd1);
    chk("abort status", 32'(status), 32'd0);
    chk("abort aluA", aluA, 32'd0);
    chk("abort aluB", aluB, 32'd0);
    chk("abort ctrl", 32'(controlUnitOut), 32'd0);
    foreach (exp_regs[i]) exp_regs[i] = '0;
    check_regs("abort");
    resetN = 1'b1;
    #1;
    chk("release ready", 32'(instrReady), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort no done", 32'(seen), 32'd0);
    check_regs("post abort");

    // instrValid held high across two instructions.
    b1 = mv(mk(7'h40, 3'd1, 3'd0, 3'd0, 16'h0007), 1'b1, 7'd0, 32'h0, 32'h7, 32'h7, 6'b001000);
    b2 = mv(mk(7'h40, 3'd2, 3'd0, 3'd0, 16'h0009), 1'b1, 7'd0, 32'h0, 32'h9, 32'h9, 6'b000000);
    instrIn    = b1.instr;
    instrValid = 1'b1;
    acc1       = cyc + 1;
    sb.push_back(b1);
    @(negedge clk);
    instrIn = b2.instr;
    chk("b2b busy", 32'(instrReady), 32'd0);
    wait_done(acc1, lat);
    chk("b2b first latency", 32'(lat), 32'd3);
    chk("b2b ready at done", 32'(instrReady), 32'd1);
    b1 = sb.pop_front();
    chk("b2b first status", 32'(status), 32'(b1.stat));
    exp_regs[1] = b1.wval;
    acc2 = cyc + 1;
    sb.push_back(b2);
    @(negedge clk);
    instrValid = 1'b0;
    chk("b2b second accepted", 32'(instrReady), 32'd0);
    chk("b2b gap", 32'(acc2 - acc1), 32'd4);
    wait_done(acc2, lat);
    chk("b2b second latency", 32'(lat), 32'd3);
    b2 = sb.pop_front();
    chk("b2b second status", 32'(status), 32'(b2.stat));
    exp_regs[2] = b2.wval;
    @(negedge clk);
    check_regs("b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand, result and register width.
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 3, giving 8 general registers.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port instrIn, input, 32 bits: instruction word {opcode[31:25], rd[24:22], rs1[21:19], rs2[18:16], imm16[15:0]}.
REQ-006 The block SHALL have port instrValid, input, 1 bit: instrIn is valid.
REQ-007 The block SHALL have port instrReady, output, 1 bit: the block accepts an instruction this cycle.
REQ-008 The block SHALL have port controlUnitOut, output, 7 bits: ALU operation code (0 OR, 1 AND, 2 XOR, 3 ADD, 4 SUB, 5 SHIFT).
REQ-009 The block SHALL have ports aluA and aluB, output, DATA_WIDTH bits each: ALU operands.
REQ-010 The block SHALL have port aluOut, input, DATA_WIDTH bits: combinational ALU result.
REQ-011 The block SHALL have ports cOut, negative, zero, parity and overflow, input, 1 bit each: ALU flags.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port status, output, 6 bits: {illegal, overflow, parity, zero, negative, cOut} of the last completed instruction.
REQ-014 The block SHALL have port readAddr, input, 3 bits: debug register read address.
REQ-015 The block SHALL have port readData, output, DATA_WIDTH bits: combinational register[readAddr]; r0 always reads 0.

Function
REQ-016 The block SHALL implement FSM states IDLE, DECODE, EXECUTE and WRITEBACK.
REQ-017 instrReady SHALL be 1 only in IDLE; an instruction is accepted on a rising edge where instrValid && instrReady, instrIn is latched, and the FSM moves to DECODE.
REQ-018 In DECODE, opcode[5:0] > 5 SHALL be illegal: the FSM goes to WRITEBACK with illegal=1 and no register write.
REQ-019 In DECODE, a legal opcode SHALL register controlUnitOut={1'b0,opcode[5:0]}, aluA=reg[rs1], and aluB=reg[rs2] if opcode[6]=0, else sign-extended imm16, then move to EXECUTE.
REQ-020 In EXECUTE, the block SHALL capture aluOut and the five flags, then move to WRITEBACK.
REQ-021 In WRITEBACK, the block SHALL write the captured result to reg[rd] unless rd=0 or illegal, update status, assert done for exactly that cycle, and return to IDLE.
REQ-022 Latency: an instruction accepted at edge N SHALL raise done in the cycle after edge N+3 when legal, and after edge N+2 when illegal.
REQ-023 status SHALL hold its value until the next WRITEBACK; an illegal instruction sets status=6'b100000.
REQ-024 Back-to-back instructions SHALL be accepted no sooner than the first IDLE after done, giving a 4-cycle throughput for legal instructions.
REQ-025 instrIn changes outside the accept edge SHALL have no effect.
REQ-026 Register reads in DECODE SHALL see the WRITEBACK result of the previous instruction; there is no hazard window.

Reset
REQ-027 While resetN=0, the block SHALL asynchronously set state=IDLE, all registers=0, controlUnitOut=0, aluA=0, aluB=0, done=0 and status=0.
REQ-028 Reset asserted in any state, including mid-EXECUTE, SHALL abort the instruction with no register write and no done pulse.
REQ-029 After reset deasserts, instrReady SHALL be 1 in the first cycle.

Verification
REQ-030 Bench: opcode 7'b1000000 (OR-imm), rd=1, rs1=0, imm=0x0005 -> done 3 cycles after accept; readAddr=1 gives 0x00000005; status zero=0.
REQ-031 Bench: then ADD rd=2, rs1=1, rs2=1 -> controlUnitOut=3, aluA=aluB=5, r2=0x0000000A; then SUB rd=3, rs1=0, rs2=1 -> r3=0xFFFFFFFB, status.negative=1.
REQ-032 Bench: OR-imm with imm=0x8000 -> aluB=0xFFFF8000; the same instruction with rd=0 -> readData for r0 stays 0 while done still pulses.
REQ-033 Bench: opcode 7'b0000111 -> done 2 cycles after accept, status=6'b100000, all registers unchanged.
REQ-034 Bench: resetN pulsed low during EXECUTE -> no done pulse, all registers 0, instrReady=1 the first cycle after release.
REQ-035 Bench: instrValid held high across two instructions -> the second is accepted only in the IDLE cycle after the first done pulse.
